// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a bounded memory-wait timeout into a sticky FAULT state and a retired counter.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Func,
    input  logic        Zero,
    input  logic        MemAck,
    output logic        MemReq,
    output logic        MemWe,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  PCSrc,
    output logic [3:0]  Ctrl,
    output logic        Shift,
    output logic        Regrt,
    output logic        Sext,
    output logic        Aluimm,
    output logic        M2reg,
    output logic        Jal,
    output logic [2:0]  Phase,
    output logic        Fault,
    output logic [31:0] Retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] retire_cnt;

    logic       legal, r_type;
    logic [3:0] alu_ctrl;
    logic       alu_shift, alu_imm, alu_sext;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;

    assign r_type = (Op == 6'h00);

    always_comb begin
        legal     = 1'b1;
        alu_ctrl  = 4'd0;
        alu_shift = 1'b0;
        alu_imm   = 1'b0;
        alu_sext  = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        if (r_type) begin
            case (Func)
                6'h20: alu_ctrl = 4'd0;
                6'h22: alu_ctrl = 4'd4;
                6'h24: alu_ctrl = 4'd1;
                6'h25: alu_ctrl = 4'd5;
                6'h26: alu_ctrl = 4'd2;
                6'h00: begin alu_ctrl = 4'd3;  alu_shift = 1'b1; end
                6'h02: begin alu_ctrl = 4'd7;  alu_shift = 1'b1; end
                6'h03: begin alu_ctrl = 4'd15; alu_shift = 1'b1; end
                6'h08: is_jr = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            case (Op)
                6'h08: begin alu_ctrl = 4'd0; alu_imm = 1'b1; alu_sext = 1'b1; end
                6'h0C: begin alu_ctrl = 4'd1; alu_imm = 1'b1; end
                6'h0D: begin alu_ctrl = 4'd5; alu_imm = 1'b1; end
                6'h0E: begin alu_ctrl = 4'd2; alu_imm = 1'b1; end
                6'h0F: begin alu_ctrl = 4'd6; alu_imm = 1'b1; end
                6'h23: begin alu_imm = 1'b1; alu_sext = 1'b1; is_lw = 1'b1; end
                6'h2B: begin alu_imm = 1'b1; alu_sext = 1'b1; is_sw = 1'b1; end
                6'h04: begin alu_ctrl = 4'd2; alu_sext = 1'b1; is_beq = 1'b1; end
                6'h05: begin alu_ctrl = 4'd2; alu_sext = 1'b1; is_bne = 1'b1; end
                6'h02: is_j   = 1'b1;
                6'h03: is_jal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        MemReq    = 1'b0;
        MemWe     = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        PCSrc     = 2'b00;
        Ctrl      = 4'd0;
        Shift     = 1'b0;
        Regrt     = 1'b0;
        Sext      = 1'b0;
        Aluimm    = 1'b0;
        M2reg     = 1'b0;
        Jal       = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
                if (!legal) begin
                    state_nxt = S_FAULT;
                end else if (is_j || is_jal) begin
                    PCWrite   = 1'b1;
                    PCSrc     = 2'b11;
                    RegWrite  = is_jal;
                    Jal       = is_jal;
                    state_nxt = S_FETCH;
                end else if (is_jr) begin
                    PCWrite   = 1'b1;
                    PCSrc     = 2'b10;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                Ctrl   = alu_ctrl;
                Shift  = alu_shift;
                Aluimm = alu_imm;
                Sext   = alu_sext;
                if (is_beq || is_bne) begin
                    if ((is_beq && Zero) || (is_bne && !Zero)) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b01;
                    end
                    state_nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                MemReq = 1'b1;
                MemWe  = is_sw;
                Aluimm = 1'b1;
                // An ack arriving on the final allowed cycle still completes normally.
                if (MemAck)
                    state_nxt = is_sw ? S_FETCH : S_WB;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = S_FAULT;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                Regrt     = !r_type;
                M2reg     = is_lw;
                state_nxt = S_FETCH;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_FETCH;
            wait_cnt   <= 8'd0;
            retire_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == S_FETCH || state_nxt == S_MEM) && state_nxt != state)
                wait_cnt <= 8'd0;
            else if (MemReq && !MemAck)
                wait_cnt <= wait_cnt + 8'd1;
            if (state_nxt == S_FETCH && state != S_FETCH)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign Phase   = state;
    assign Fault   = (state == S_FAULT);
    assign Retired = retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output records go through
// a scoreboard queue and are compared against the DUT's combinational outputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0]  phase;
        logic        fault, mreq, mwe, irw, pcw, rw;
        logic [1:0]  pcsrc;
        logic [3:0]  ctrl;
        logic        shift, regrt, sext, aluimm, m2reg, jal;
        logic [31:0] ret;
    } obs_t;

    logic        Clk = 1'b0;
    logic        Reset, Zero, MemAck;
    logic [5:0]  Op, Func;
    logic        MemReq, MemWe, IRWrite, PCWrite, RegWrite;
    logic [1:0]  PCSrc;
    logic [3:0]  Ctrl;
    logic        Shift, Regrt, Sext, Aluimm, M2reg, Jal, Fault;
    logic [2:0]  Phase;
    logic [31:0] Retired;

    obs_t        sb[$];
    string       tags[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ret     = 32'd0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Zero(Zero), .MemAck(MemAck),
        .MemReq(MemReq), .MemWe(MemWe), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .PCSrc(PCSrc), .Ctrl(Ctrl), .Shift(Shift), .Regrt(Regrt),
        .Sext(Sext), .Aluimm(Aluimm), .M2reg(M2reg), .Jal(Jal), .Phase(Phase),
        .Fault(Fault), .Retired(Retired)
    );

    always #5 Clk = ~Clk;

    function automatic obs_t mk(input logic [2:0] ph);
        obs_t r;
        r       = '0;
        r.phase = ph;
        r.fault = (ph == 3'd5);
        r.ret   = ret;
        return r;
    endfunction

    function automatic obs_t f_fetch(input logic ack);
        obs_t r;
        r      = mk(3'd0);
        r.mreq = 1'b1;
        r.irw  = ack;
        r.pcw  = ack;
        return r;
    endfunction

    function automatic obs_t f_exec(input logic [3:0] c, input logic sh, input logic imm, input logic sx);
        obs_t r;
        r        = mk(3'd2);
        r.ctrl   = c;
        r.shift  = sh;
        r.aluimm = imm;
        r.sext   = sx;
        return r;
    endfunction

    function automatic obs_t f_mem(input logic we);
        obs_t r;
        r        = mk(3'd3);
        r.mreq   = 1'b1;
        r.mwe    = we;
        r.aluimm = 1'b1;
        return r;
    endfunction

    function automatic obs_t f_wb(input logic rt, input logic m2r);
        obs_t r;
        r       = mk(3'd4);
        r.rw    = 1'b1;
        r.regrt = rt;
        r.m2reg = m2r;
        return r;
    endfunction

    task automatic check_out();
        obs_t  o, e;
        string t;
        o = {Phase, Fault, MemReq, MemWe, IRWrite, PCWrite, RegWrite, PCSrc, Ctrl,
             Shift, Regrt, Sext, Aluimm, M2reg, Jal, Retired};
        e = sb.pop_front();
        t = tags.pop_front();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, sample mid-cycle, advance.
    task automatic step(input string tag, input obs_t e, input logic ack, input logic z);
        MemAck = ack;
        Zero   = z;
        sb.push_back(e);
        tags.push_back(tag);
        #3;
        check_out();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [3:0] c, input logic sh, input logic imm, input logic sx);
        Op = op; Func = fn;
        step({tag, "_fetch"}, f_fetch(1'b1), 1'b1, 1'b0);
        step({tag, "_dec"},   mk(3'd1), 1'b0, 1'b0);
        step({tag, "_exec"},  f_exec(c, sh, imm, sx), 1'b0, 1'b0);
        step({tag, "_wb"},    f_wb(op != 6'h00, 1'b0), 1'b0, 1'b0);
        ret++;
    endtask

    task automatic run_br(input string tag, input logic [5:0] op, input logic z, input logic taken);
        obs_t e;
        Op = op; Func = 6'h00;
        step({tag, "_fetch"}, f_fetch(1'b1), 1'b1, 1'b0);
        step({tag, "_dec"},   mk(3'd1), 1'b0, 1'b0);
        e = f_exec(4'd2, 1'b0, 1'b0, 1'b1);
        if (taken) begin e.pcw = 1'b1; e.pcsrc = 2'b01; end
        step({tag, "_exec"}, e, 1'b0, z);
        ret++;
    endtask

    task automatic run_mem(input string tag, input logic wr, input int delay);
        Op = wr ? 6'h2B : 6'h23; Func = 6'h00;
        step({tag, "_fetch"}, f_fetch(1'b1), 1'b1, 1'b0);
        step({tag, "_dec"},   mk(3'd1), 1'b0, 1'b0);
        step({tag, "_exec"},  f_exec(4'd0, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        for (int i = 0; i < delay; i++)
            step({tag, "_memwait"}, f_mem(wr), 1'b0, 1'b0);
        step({tag, "_memack"}, f_mem(wr), 1'b1, 1'b0);
        if (!wr) step({tag, "_wb"}, f_wb(1'b1, 1'b1), 1'b0, 1'b0);
        ret++;
    endtask

    task automatic run_jmp(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [1:0] src, input logic link);
        obs_t e;
        Op = op; Func = fn;
        step({tag, "_fetch"}, f_fetch(1'b1), 1'b1, 1'b0);
        e = mk(3'd1);
        e.pcw = 1'b1; e.pcsrc = src; e.rw = link; e.jal = link;
        step({tag, "_dec"}, e, 1'b0, 1'b0);
        ret++;
    endtask

    initial begin
        Reset = 1'b1; Op = 6'h00; Func = 6'h20; Zero = 1'b0; MemAck = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        step("reset_fetch", f_fetch(1'b0), 1'b0, 1'b0);
        step("idle_fetch",  f_fetch(1'b0), 1'b0, 1'b0);

        run_alu("add",  6'h00, 6'h20, 4'd0,  1'b0, 1'b0, 1'b0);
        step("add_retired", f_fetch(1'b0), 1'b0, 1'b0);
        run_br("beq_z1", 6'h04, 1'b1, 1'b1);
        run_br("beq_z0", 6'h04, 1'b0, 1'b0);
        run_br("bne_z0", 6'h05, 1'b0, 1'b1);
        run_br("bne_z1", 6'h05, 1'b1, 1'b0);
        run_alu("ori",  6'h0D, 6'h00, 4'd5,  1'b0, 1'b1, 1'b0);
        run_alu("lui",  6'h0F, 6'h00, 4'd6,  1'b0, 1'b1, 1'b0);
        run_alu("addi", 6'h08, 6'h00, 4'd0,  1'b0, 1'b1, 1'b1);
        run_alu("sll",  6'h00, 6'h00, 4'd3,  1'b1, 1'b0, 1'b0);
        run_alu("sra",  6'h00, 6'h03, 4'd15, 1'b1, 1'b0, 1'b0);
        run_alu("sub",  6'h00, 6'h22, 4'd4,  1'b0, 1'b0, 1'b0);
        run_mem("lw_d3", 1'b0, 3);
        run_mem("sw_d0", 1'b0 | 1'b1, 0);
        run_mem("sw_ack_last", 1'b1, 14);
        run_jmp("j",  6'h02, 6'h00, 2'b11, 1'b0);
        run_jmp("jr", 6'h00, 6'h08, 2'b10, 1'b0);

        // Preload Retired to its maximum and let jal wrap it.
        step("pre_wrap_fetch", f_fetch(1'b0), 1'b0, 1'b0);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        ret = 32'hFFFF_FFFF;
        run_jmp("jal_wrap", 6'h03, 6'h00, 2'b11, 1'b1);
        step("wrap_fetch", f_fetch(1'b0), 1'b0, 1'b0);

        // sw with no ack: 15 MEM cycles then sticky FAULT, ack ignored.
        Op = 6'h2B; Func = 6'h00;
        step("sw_to_fetch", f_fetch(1'b1), 1'b1, 1'b0);
        step("sw_to_dec",   mk(3'd1), 1'b0, 1'b0);
        step("sw_to_exec",  f_exec(4'd0, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            step("sw_to_mem", f_mem(1'b1), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("fault_sticky", mk(3'd5), 1'b1, 1'b0);
        Reset = 1'b1;
        step("fault_in_reset", mk(3'd5), 1'b0, 1'b0);
        Reset = 1'b0; ret = 32'd0;
        step("post_fault_fetch", f_fetch(1'b0), 1'b0, 1'b0);

        run_alu("xor", 6'h00, 6'h26, 4'd2, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of a store access.
        Op = 6'h2B; Func = 6'h00;
        step("swr_fetch", f_fetch(1'b1), 1'b1, 1'b0);
        step("swr_dec",   mk(3'd1), 1'b0, 1'b0);
        step("swr_exec",  f_exec(4'd0, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        step("swr_mem",   f_mem(1'b1), 1'b0, 1'b0);
        Reset = 1'b1;
        step("swr_mem_rst", f_mem(1'b1), 1'b0, 1'b0);
        Reset = 1'b0; ret = 32'd0;
        step("swr_after_rst", f_fetch(1'b0), 1'b0, 1'b0);

        // Unsupported opcode faults out of DECODE.
        Op = 6'h3F; Func = 6'h00;
        step("bad_fetch", f_fetch(1'b1), 1'b1, 1'b0);
        step("bad_dec",   mk(3'd1), 1'b0, 1'b0);
        step("bad_fault", mk(3'd5), 1'b1, 1'b0);
        Op = 6'h00; Func = 6'h3F;
        Reset = 1'b1;
        step("bad_rst", mk(3'd5), 1'b0, 1'b0);
        Reset = 1'b0; ret = 32'd0;
        step("badfn_fetch", f_fetch(1'b1), 1'b1, 1'b0);
        step("badfn_dec",   mk(3'd1), 1'b0, 1'b0);
        step("badfn_fault", mk(3'd5), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max wait cycles for MemAck per access before FAULT (1..255).
REQ-002 Clk  input  1  rising-edge clock; single clock domain.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  6  IR opcode field; stable from DECODE until next IRWrite.
REQ-005 Func  input  6  IR function field; same stability as Op.
REQ-006 Zero  input  1  ALU result == 0, valid in EXEC.
REQ-007 MemAck  input  1  memory completion; honoured only while MemReq=1.
REQ-008 MemReq, MemWe  output  1 each  memory request / write enable.
REQ-009 IRWrite, PCWrite, RegWrite  output  1 each  single-cycle write strobes.
REQ-010 PCSrc  output  2  00 PC+4, 01 branch target, 10 register (jr), 11 jump target.
REQ-011 Ctrl  output  4  ALU op: add 0, and 1, xor 2, sll 3, sub 4, or 5, lui 6, srl 7, sra 15.
REQ-012 Shift, Regrt, Sext, Aluimm, M2reg, Jal  output  1 each  datapath mux/extend selects.
REQ-013 Phase  output  3  state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, FAULT 5.
REQ-014 Fault  output  1  high in FAULT.
REQ-015 Retired  output  32  completed-instruction count.

Function
REQ-016 Outputs SHALL be combinational from state, Op/Func and Zero; strobes SHALL be 0 outside the states listed below.
REQ-017 FETCH: MemReq=1, MemWe=0; on MemAck, IRWrite=1, PCWrite=1 with PCSrc=00 in the same cycle; next state DECODE.
REQ-018 DECODE: unsupported Op/Func -> FAULT; j -> PCWrite=1, PCSrc=11, then FETCH; jal -> PCWrite=1, PCSrc=11, RegWrite=1, Jal=1, then FETCH; jr -> PCWrite=1, PCSrc=10, then FETCH; all other opcodes -> EXEC.
REQ-019 Supported set: R-type add, sub, and, or, xor, sll, srl, sra, jr; addi, andi, ori, xori, lui, lw, sw, beq, bne, j, jal.
REQ-020 EXEC: Ctrl/Shift/Aluimm/Sext per opcode (Sext=1 for addi, lw, sw, beq, bne; else 0); beq/bne use Ctrl=2 and assert PCWrite with PCSrc=01 iff (beq & Zero) or (bne & !Zero), then FETCH; lw/sw -> MEM; others -> WB.
REQ-021 MEM: MemReq=1, MemWe=1 iff sw, Ctrl=0, Aluimm=1; on MemAck, sw -> FETCH and lw -> WB.
REQ-022 WB: RegWrite=1 for exactly one cycle; Regrt=1 for I-type, 0 for R-type; M2reg=1 iff lw; then FETCH.
REQ-023 Wait counter SHALL clear on entering FETCH or MEM and increment each cycle MemReq=1 without MemAck; reaching MEM_TIMEOUT -> FAULT.
REQ-024 MemAck in the cycle the counter reaches MEM_TIMEOUT SHALL win (normal transition).
REQ-025 FAULT SHALL be sticky until Reset; all strobes and MemReq are 0.
REQ-026 Retired SHALL increment by 1 on every transition into FETCH from a non-FETCH state, wrapping 0xFFFFFFFF -> 0.
REQ-027 MemAck outside FETCH/MEM SHALL be ignored.

Reset
REQ-028 Reset sampled high SHALL, at that edge, force Phase=FETCH, wait counter=0, Retired=0, Fault=0, overriding any in-flight state including MEM mid-access.
REQ-029 The cycle after reset SHALL present MemReq=1, MemWe=0 and all strobes 0 except as FETCH defines.

Verification
REQ-030 add: MemAck in FETCH -> IRWrite, PCWrite pulse; DECODE, EXEC Ctrl=0, WB RegWrite=1, Regrt=0; Retired=1 after 4 cycles.
REQ-031 beq, Zero=1 -> EXEC PCWrite=1, PCSrc=01, next FETCH; repeat with Zero=0 -> PCWrite=0.
REQ-032 lw with MemAck delayed 3 cycles in MEM -> MemReq held 4 cycles, MemWe=0; WB M2reg=1, RegWrite=1.
REQ-033 sw, MemAck never asserted, MEM_TIMEOUT=15 -> FAULT after 15 MEM cycles; MemReq=0, Fault=1 until Reset.
REQ-034 Reset asserted during MEM of sw -> next cycle Phase=0, MemWe=0, Retired=0.
REQ-035 Retired preloaded to 0xFFFFFFFF via 2^32-1 completions (or force) then jal -> Retired=0, RegWrite=1, Jal=1, PCSrc=11.
